comb_prim: RTL and testbench
============================

Name: comb_prim

Overview:
- 4-bit prime-number detector. The input word N = {A,B,C,D} has A as the MSB.
- Y is a purely combinational flag, asserted when N is prime.
- A registered copy of the flag and a saturating prime-hit counter are added for use in the clocked datapath.
- Sits as a leaf primitive; downstream logic may use either the combinational or the registered result.

Parameters:
- CNT_WIDTH, 8, width of the prime-hit counter prime_cnt (legal range 1..16).

Ports:
- clk  input  1  system clock, rising-edge active.
- rst_n  input  1  asynchronous active-low reset.
- A  input  1  bit 3 (MSB) of N.
- B  input  1  bit 2 of N.
- C  input  1  bit 1 of N.
- D  input  1  bit 0 (LSB) of N.
- en  input  1  sample enable for the registered path and the counter.
- clr  input  1  synchronous clear of the counter and the registered flag.
- Y  output  1  combinational prime flag for the current N.
- Y_q  output  1  registered prime flag.
- prime_cnt  output  CNT_WIDTH  number of enabled samples that were prime.
- cnt_sat  output  1  high while prime_cnt is at its all-ones value.

Behaviour:
- Y = 1 exactly for N in {2,3,5,7,11,13} (binary 0010, 0011, 0101, 0111, 1011, 1101).
- Y = 0 for all other N, including 0 and 1.
- Y is independent of clk, rst_n, en and clr. It is zero-latency: it settles in the same delta as any change on A..D, with no latches.
- The canonical minimal SOP is Y = A'B'C + B'CD + BC'D + A'BD. Any equivalent form is acceptable.
- Reset: rst_n low asynchronously forces Y_q=0, prime_cnt=0 and cnt_sat=0, and holds them while low. Y is unaffected by reset.
- Registers update on the rising clk edge after rst_n is released.
- Priority at each rising edge, highest first:
  1. clr=1: Y_q<=0, prime_cnt<=0. This wins over en.
  2. en=1: Y_q<=Y, and prime_cnt increments by 1 if Y=1 and prime_cnt is not all-ones.
  3. Otherwise: all registers hold.
- Y_q latency is one clock from the sampled edge.
- Saturation: prime_cnt stops at 2^CNT_WIDTH-1 and never wraps. Further prime samples are ignored.
- cnt_sat is combinational from prime_cnt: it is 1 iff prime_cnt is all-ones.
- clr and en both high in the same cycle: the counter clears and the current sample is not counted.
- X/Z on A..D is not defined behaviour. The bench drives only 0/1.

Test Plan:
- Exhaustive truth table: step N from 0000 through 1111 and wrap back through 0011 (20 steps, 100 ns apart). Require Y=1 only at 2,3,5,7,11,13 and Y=0 at 0,1,4,6,8,9,10,12,14,15. Require the same values after the wrap.
- Registered path: with en=1, drive N=5 then N=4 on successive edges. Require Y_q=1 one cycle after N=5 and Y_q=0 one cycle after N=4. With en=0, Y_q holds.
- Counter: with en=1, sweep all 16 values once. Require prime_cnt=6 and cnt_sat=0.
- Saturation: with CNT_WIDTH=2, en=1, hold N=7 for 5 edges. Require prime_cnt to go 1,2,3,3,3, with cnt_sat=1 from the third edge on.
- Clear priority: with prime_cnt=4, assert clr=1 and en=1 with N=11 for one edge. Require prime_cnt=0 and Y_q=0 afterwards, while Y=1 throughout.
- Async reset: pull rst_n low between clock edges with prime_cnt=3 and Y_q=1. Require prime_cnt=0, Y_q=0 and cnt_sat=0 immediately, with no clk edge, while Y still tracks N.

Source files
------------

// File: rtl/comb_prim_if.sv
// -----------------------------------------------------------------------------
// comb_prim_if : signal bundle for the comb_prim prime-number detector.
//
// Signals (master = driver of N/en/clr, slave = the detector):
//   A,B,C,D    N = {A,B,C,D}, A is the MSB
//   en         sample enable for the registered flag and the counter
//   clr        synchronous clear of the counter and the registered flag
//   Y          combinational prime flag for the current N
//   Y_q        registered prime flag
//   prime_cnt  saturating count of enabled prime samples
//   cnt_sat    high while prime_cnt is all-ones
// -----------------------------------------------------------------------------
interface comb_prim_if #(
  parameter int CNT_WIDTH = 8
);
  logic                 A;
  logic                 B;
  logic                 C;
  logic                 D;
  logic                 en;
  logic                 clr;
  logic                 Y;
  logic                 Y_q;
  logic [CNT_WIDTH-1:0] prime_cnt;
  logic                 cnt_sat;

  modport master (
    output A, B, C, D, en, clr,
    input  Y, Y_q, prime_cnt, cnt_sat
  );

  modport slave (
    input  A, B, C, D, en, clr,
    output Y, Y_q, prime_cnt, cnt_sat
  );
endinterface

// File: rtl/comb_prim.sv
// -----------------------------------------------------------------------------
// comb_prim : 4-bit prime-number detector with a registered flag and a
// saturating prime-hit counter.
//
// Ports:
//   clk    system clock, rising-edge active
//   rst_n  asynchronous active-low reset (clears Y_q and prime_cnt)
//   bus    comb_prim_if.slave
//            in : A,B,C,D (N, A = MSB), en, clr
//            out: Y (combinational), Y_q, prime_cnt, cnt_sat
//
// The CNT_WIDTH parameter must match the one of the connected interface.
// -----------------------------------------------------------------------------
module comb_prim #(
  parameter int CNT_WIDTH = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  comb_prim_if.slave  bus
);

  logic                 y_comb;
  logic                 y_q_r;
  logic [CNT_WIDTH-1:0] cnt_r;
  logic                 cnt_full;

  // Minimal SOP for N in {2,3,5,7,11,13}; continuous assign, so no storage.
  assign y_comb = (~bus.A & ~bus.B &  bus.C)
                | (~bus.B &  bus.C &  bus.D)
                | ( bus.B & ~bus.C &  bus.D)
                | (~bus.A &  bus.B &  bus.D);

  assign cnt_full = &cnt_r;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      y_q_r <= 1'b0;
      cnt_r <= '0;
    end else if (bus.clr) begin
      // Clear wins over en: the sample on this edge is discarded.
      y_q_r <= 1'b0;
      cnt_r <= '0;
    end else if (bus.en) begin
      y_q_r <= y_comb;
      if (y_comb && !cnt_full) begin
        cnt_r <= cnt_r + CNT_WIDTH'(1);
      end
    end
  end

  assign bus.Y         = y_comb;
  assign bus.Y_q       = y_q_r;
  assign bus.prime_cnt = cnt_r;
  assign bus.cnt_sat   = cnt_full;

endmodule

// File: tb/tb_comb_prim.sv
// -----------------------------------------------------------------------------
// tb_comb_prim : self-checking bench for comb_prim.
// Two instances share clock, reset and inputs: CNT_WIDTH=8 (default) and
// CNT_WIDTH=2 (for counter saturation).
// -----------------------------------------------------------------------------
module tb_comb_prim;

  logic clk;
  logic rst_n;

  comb_prim_if #(.CNT_WIDTH(8)) if8 ();
  comb_prim_if #(.CNT_WIDTH(2)) if2 ();

  comb_prim #(.CNT_WIDTH(8)) dut8 (.clk(clk), .rst_n(rst_n), .bus(if8.slave));
  comb_prim #(.CNT_WIDTH(2)) dut2 (.clk(clk), .rst_n(rst_n), .bus(if2.slave));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vec_cnt  = 0;
  int miss_cnt = 0;

  typedef struct {
    logic [3:0] n;
    logic       exp_y;
  } tt_vec_t;

  // Reference: primality by trial division.
  function automatic logic is_prime(input int n);
    if (n < 2) return 1'b0;
    for (int d = 2; d * d <= n; d++) begin
      if (n % d == 0) return 1'b0;
    end
    return 1'b1;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    vec_cnt++;
    if (act !== exp) begin
      miss_cnt++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic [3:0] n, input logic e, input logic c);
    {if8.A, if8.B, if8.C, if8.D} = n;
    {if2.A, if2.B, if2.C, if2.D} = n;
    if8.en  = e;
    if2.en  = e;
    if8.clr = c;
    if2.clr = c;
  endtask

  // Advance one rising edge and settle just after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  tt_vec_t tt[20];

  // Behavioural model state for the random phase.
  int       m_cnt8;
  int       m_cnt2;
  logic     m_yq;

  initial begin
    // 20-step truth-table sweep: 0..15 then wrap through 3.
    for (int i = 0; i < 20; i++) begin
      tt[i].n     = 4'(i % 16);
      tt[i].exp_y = ((i % 16) == 2 || (i % 16) == 3 || (i % 16) == 5 ||
                     (i % 16) == 7 || (i % 16) == 11 || (i % 16) == 13);
    end

    rst_n = 1'b0;
    drive(4'd0, 1'b0, 1'b0);
    #23;
    check("reset Y_q", if8.Y_q, 0);
    check("reset prime_cnt", if8.prime_cnt, 0);
    check("reset cnt_sat", if8.cnt_sat, 0);
    check("reset cnt_sat w2", if2.cnt_sat, 0);
    #4;
    rst_n = 1'b1;

    // Truth table, en=0 so registers stay idle.
    for (int i = 0; i < 20; i++) begin
      drive(tt[i].n, 1'b0, 1'b0);
      #1;
      check($sformatf("truth Y N=%0d", tt[i].n), if8.Y, tt[i].exp_y);
      check($sformatf("truth Y w2 N=%0d", tt[i].n), if2.Y, tt[i].exp_y);
      #99;
    end
    check("idle prime_cnt", if8.prime_cnt, 0);

    // Registered path.
    drive(4'd5, 1'b1, 1'b0);
    step();
    check("Y_q after N=5", if8.Y_q, 1);
    drive(4'd4, 1'b1, 1'b0);
    step();
    check("Y_q after N=4", if8.Y_q, 0);
    drive(4'd13, 1'b0, 1'b0);
    step();
    check("Y_q hold en=0", if8.Y_q, 0);
    drive(4'd13, 1'b1, 1'b0);
    step();
    check("Y_q after N=13", if8.Y_q, 1);
    drive(4'd8, 1'b0, 1'b0);
    step();
    check("Y_q hold high en=0", if8.Y_q, 1);

    // Counter sweep of all 16 values.
    drive(4'd0, 1'b0, 1'b1);
    step();
    check("clr prime_cnt", if8.prime_cnt, 0);
    for (int n = 0; n < 16; n++) begin
      drive(4'(n), 1'b1, 1'b0);
      step();
    end
    check("sweep prime_cnt", if8.prime_cnt, 6);
    check("sweep cnt_sat", if8.cnt_sat, 0);

    // Saturation on the 2-bit counter: N=7 for five edges.
    drive(4'd0, 1'b0, 1'b1);
    step();
    for (int k = 1; k <= 5; k++) begin
      drive(4'd7, 1'b1, 1'b0);
      step();
      check($sformatf("sat cnt edge %0d", k), if2.prime_cnt, (k < 3) ? k : 3);
      check($sformatf("sat flag edge %0d", k), if2.cnt_sat, (k >= 3) ? 1 : 0);
    end

    // Clear priority: bring count to 4, then clr+en with N=11.
    drive(4'd0, 1'b0, 1'b1);
    step();
    for (int k = 0; k < 4; k++) begin
      drive((k == 0) ? 4'd2 : (k == 1) ? 4'd3 : (k == 2) ? 4'd5 : 4'd7,
            1'b1, 1'b0);
      step();
    end
    check("pre-clr prime_cnt", if8.prime_cnt, 4);
    drive(4'd11, 1'b1, 1'b1);
    #1;
    check("clr Y before", if8.Y, 1);
    step();
    check("clr prime_cnt", if8.prime_cnt, 0);
    check("clr Y_q", if8.Y_q, 0);
    check("clr Y after", if8.Y, 1);

    // Async reset between edges with prime_cnt=3, Y_q=1.
    drive(4'd0, 1'b0, 1'b1);
    step();
    for (int k = 0; k < 3; k++) begin
      drive((k == 0) ? 4'd2 : (k == 1) ? 4'd3 : 4'd5, 1'b1, 1'b0);
      step();
    end
    check("pre-rst prime_cnt", if8.prime_cnt, 3);
    check("pre-rst Y_q", if8.Y_q, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("async rst prime_cnt", if8.prime_cnt, 0);
    check("async rst Y_q", if8.Y_q, 0);
    check("async rst cnt_sat", if8.cnt_sat, 0);
    check("async rst w2 cnt", if2.prime_cnt, 0);
    drive(4'd13, 1'b0, 1'b0);
    #1;
    check("rst Y tracks 13", if8.Y, 1);
    drive(4'd9, 1'b0, 1'b0);
    #1;
    check("rst Y tracks 9", if8.Y, 0);
    #1;
    rst_n = 1'b1;

    // Randomized run against the behavioural model.
    m_cnt8 = 0;
    m_cnt2 = 0;
    m_yq   = 1'b0;
    for (int i = 0; i < 400; i++) begin
      logic [3:0] n;
      logic       e;
      logic       c;
      n = 4'($urandom_range(0, 15));
      e = ($urandom_range(0, 3) != 0);
      c = ($urandom_range(0, 39) == 0);
      drive(n, e, c);
      #1;
      check("rand Y", if8.Y, is_prime(int'(n)));
      if (c) begin
        m_yq   = 1'b0;
        m_cnt8 = 0;
        m_cnt2 = 0;
      end else if (e) begin
        m_yq = is_prime(int'(n));
        if (m_yq) begin
          m_cnt8 = (m_cnt8 + 1 > 255) ? 255 : m_cnt8 + 1;
          m_cnt2 = (m_cnt2 + 1 > 3) ? 3 : m_cnt2 + 1;
        end
      end
      step();
      check("rand Y_q", if8.Y_q, m_yq);
      check("rand cnt8", if8.prime_cnt, m_cnt8);
      check("rand sat8", if8.cnt_sat, (m_cnt8 == 255) ? 1 : 0);
      check("rand cnt2", if2.prime_cnt, m_cnt2);
      check("rand sat2", if2.cnt_sat, (m_cnt2 == 3) ? 1 : 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
    $finish;
  end

endmodule
